// File: rtl/mux8x1_pkg.sv
// Shared definitions for the 8-to-1 x 4-bit TDM mux link (mux and demux sides).
package mux8x1_pkg;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned CHANNELS = 8;
    localparam int unsigned SEL_W    = 3;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        COLLECT_AUTO = 2'd1,
        COLLECT_ADDR = 2'd2
    } state_e;

    typedef logic [CHANNELS-1:0][WIDTH-1:0] chan_arr_t;

endpackage

// File: rtl/tdm_slot_tracker.sv
// Slot counter, addressed-mode coverage mask and frame completion/abort detection.
module tdm_slot_tracker
    import mux8x1_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  state_e           state,
    input  logic             sel_mode,
    input  logic             d_valid,
    input  logic             sof,
    input  logic [SEL_W-1:0] s_in,
    output logic             wr_en,
    output logic [SEL_W-1:0] wr_idx,
    output logic             frame_done,
    output logic             abort,
    output logic [SEL_W-1:0] slot
);

    logic [SEL_W-1:0]    slot_q, slot_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] hit;
    logic                start_auto, start_addr, auto_wr, addr_wr;

    // Decode the current sample: where it goes and whether it closes or aborts a frame.
    always_comb begin
        start_auto = (state == IDLE) && !sel_mode && d_valid && sof;
        start_addr = (state == IDLE) && sel_mode && d_valid;
        auto_wr    = (state == COLLECT_AUTO) && d_valid;
        addr_wr    = (state == COLLECT_ADDR) && d_valid;

        hit       = '0;
        hit[s_in] = 1'b1;

        abort      = auto_wr && sof;
        frame_done = (auto_wr && !sof && (slot_q == SEL_W'(CHANNELS - 1)))
                   || (addr_wr && ((mask_q | hit) == '1));

        wr_en  = start_auto || start_addr || auto_wr || addr_wr;
        wr_idx = '0;
        if (start_addr || addr_wr) begin
            wr_idx = s_in;
        end else if (auto_wr && !sof) begin
            wr_idx = slot_q;
        end

        slot_d = slot_q;
        if (start_auto || abort) begin
            slot_d = SEL_W'(1);
        end else if (auto_wr) begin
            // 7 -> 0 wrap marks the end of the frame
            slot_d = slot_q + SEL_W'(1);
        end

        mask_d = mask_q;
        if (start_addr) begin
            mask_d = hit;
        end else if (addr_wr) begin
            mask_d = frame_done ? '0 : (mask_q | hit);
        end
    end

    // Slot counter and coverage mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
            mask_q <= '0;
        end else begin
            slot_q <= slot_d;
            mask_q <= mask_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/demux8x1_tdm_rx.sv
// Rebuilds eight 4-bit channels from the TDM mux stream; q_out updates once per full frame.
module demux8x1_tdm_rx #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [WIDTH-1:0]               d_in,
    input  logic                           d_valid,
    input  logic                           sof,
    input  logic                           sel_mode,
    input  logic [2:0]                     s_in,
    output logic [CHANNELS-1:0][WIDTH-1:0] q_out,
    output logic                           frame_valid,
    output logic [2:0]                     slot,
    output logic                           err_sof
);
    import mux8x1_pkg::*;

    state_e                         state_q, state_d;
    logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, merged;
    logic [CHANNELS-1:0][WIDTH-1:0] q_q;
    logic                           fv_q, err_q;
    logic                           wr_en, frame_done, abort;
    logic [2:0]                     wr_idx;

    tdm_slot_tracker u_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .state      (state_q),
        .sel_mode   (sel_mode),
        .d_valid    (d_valid),
        .sof        (sof),
        .s_in       (s_in),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .frame_done (frame_done),
        .abort      (abort),
        .slot       (slot)
    );

    // Shadow bank with the current sample merged in, so the completing sample lands in q_out.
    always_comb begin
        merged = shadow_q;
        if (wr_en) begin
            merged[wr_idx] = d_in;
        end
    end

    // Next-state logic; sel_mode only matters while idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (d_valid && sel_mode) begin
                    state_d = COLLECT_ADDR;
                end else if (d_valid && sof) begin
                    state_d = COLLECT_AUTO;
                end
            end
            COLLECT_AUTO, COLLECT_ADDR: begin
                if (frame_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shadow bank, output frame register and one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            q_q      <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= merged;
            fv_q     <= frame_done;
            err_q    <= abort;
            if (frame_done) begin
                q_q <= merged;
            end
        end
    end

    assign q_out       = q_q;
    assign frame_valid = fv_q;
    assign err_sof     = err_q;

endmodule
